// File: rtl/uart_word_packer.sv
// Packs little-endian UART bytes into 32-bit words: instruction region, then data region, then sticky load_done.
// Latency: wr_en is high the cycle after the edge that samples the 4th byte. No backpressure; every rx_dv is consumed.
// Optional inter-byte timeout that drops stale partial words: define UART_WORD_PACKER_TIMEOUT_EN.
module uart_word_packer #(
   parameter int unsigned MEM_SIZE     = 2,
   parameter int unsigned TIMEOUT_CLKS = 208340
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   output logic        wr_en,
   output logic        mem_sel,
   output logic [15:0] addr,
   output logic [31:0] wdata,
   output logic        load_done,
   output logic        err_timeout
);

   localparam int unsigned IDX_W = $clog2(2 * MEM_SIZE) + 1;
   localparam logic [IDX_W-1:0] REGION_IDX = IDX_W'(MEM_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2 * MEM_SIZE - 1);
   localparam logic [IDX_W-1:0] NUM_WORDS  = IDX_W'(2 * MEM_SIZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_q;
   logic [1:0]        byte_cnt_q;
   logic [IDX_W-1:0]  word_idx_q;
   logic [23:0]       buf_q;
   logic              wr_en_q;
   logic              mem_sel_q;
   logic [15:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              load_done_q;
   logic              mem_sel_d;
   logic [15:0]       addr_d;

   always_comb begin
      mem_sel_d = (word_idx_q >= REGION_IDX);
      addr_d    = mem_sel_d ? 16'(word_idx_q - REGION_IDX) : 16'(word_idx_q);
   end

`ifdef UART_WORD_PACKER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_hit;
   logic             err_timeout_q;

   // Counts idle cycles only while a partial word is held.
   always_ff @(posedge clk) begin
      if (!rst_n || state_q != COLLECT || rx_dv) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   assign tmo_hit     = (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1));
   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         byte_cnt_q  <= 2'd0;
         word_idx_q  <= '0;
         buf_q       <= 24'd0;
         wr_en_q     <= 1'b0;
         mem_sel_q   <= 1'b0;
         addr_q      <= 16'd0;
         wdata_q     <= 32'd0;
         load_done_q <= 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
         err_timeout_q <= 1'b0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_dv) begin
                  buf_q[7:0] <= rx_byte;
                  byte_cnt_q <= 2'd1;
                  state_q    <= COLLECT;
               end
            end
            COLLECT: begin
               if (rx_dv) begin
                  if (byte_cnt_q == 2'd3) begin
                     wr_en_q    <= 1'b1;
                     wdata_q    <= {rx_byte, buf_q};
                     mem_sel_q  <= mem_sel_d;
                     addr_q     <= addr_d;
                     word_idx_q <= word_idx_q + 1'b1;
                     byte_cnt_q <= 2'd0;
                     state_q    <= WRITE;
                     if (word_idx_q == LAST_IDX) begin
                        load_done_q <= 1'b1;
                     end
                  end else begin
                     case (byte_cnt_q)
                        2'd1:    buf_q[15:8]  <= rx_byte;
                        default: buf_q[23:16] <= rx_byte;
                     endcase
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
`ifdef UART_WORD_PACKER_TIMEOUT_EN
               else if (tmo_hit) begin
                  byte_cnt_q    <= 2'd0;
                  state_q       <= IDLE;
                  err_timeout_q <= 1'b1;
               end
`endif
            end
            WRITE: begin
               // word_idx already points past the word just written.
               if (word_idx_q == NUM_WORDS) begin
                  state_q <= DONE;
               end else if (rx_dv) begin
                  buf_q[7:0] <= rx_byte;
                  byte_cnt_q <= 2'd1;
                  state_q    <= COLLECT;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= DONE;
            end
         endcase
      end
   end

   assign wr_en     = wr_en_q;
   assign mem_sel   = mem_sel_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign load_done = load_done_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_uart_word_packer;

   logic        clk;
   logic        rst_n;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        wr_en;
   logic        mem_sel;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic        load_done;
   logic        err_timeout;

   typedef struct {
      logic        sel;
      logic [15:0] addr;
      logic [31:0] data;
      logic        ld;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   uart_word_packer #(
      .MEM_SIZE     (2),
      .TIMEOUT_CLKS (100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_dv       (rx_dv),
      .rx_byte     (rx_byte),
      .wr_en       (wr_en),
      .mem_sel     (mem_sel),
      .addr        (addr),
      .wdata       (wdata),
      .load_done   (load_done),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic push(input logic sel, input logic [15:0] a, input logic [31:0] d, input logic ld);
      exp_t e;
      e.sel  = sel;
      e.addr = a;
      e.data = d;
      e.ld   = ld;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   // Monitor: every wr_en pulse must match the oldest expected write.
   initial begin
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_wr: wr_en=1 addr=%0h wdata=%08h, no write expected", addr, wdata);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wr_sel",   {31'd0, mem_sel},   {31'd0, e.sel});
               check("wr_addr",  {16'd0, addr},      {16'd0, e.addr});
               check("wr_data",  wdata,              e.data);
               check("wr_ld",    {31'd0, load_done}, {31'd0, e.ld});
               check("wr_cycle", cyc,                e.cyc);
            end
         end
      end
   end

   // Called at a negedge; leaves the bench at a negedge.
   task automatic send(input logic [7:0] b, input int gap);
      rx_dv   = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input logic sel, input logic [15:0] a,
                            input logic ld, input int gap);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) push(sel, a, w, ld);
         send(w[8*i +: 8], gap);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_wr_en"},   {31'd0, wr_en},       32'd0);
      check({tag, "_mem_sel"}, {31'd0, mem_sel},     32'd0);
      check({tag, "_addr"},    {16'd0, addr},        32'd0);
      check({tag, "_wdata"},   wdata,                32'd0);
      check({tag, "_ld"},      {31'd0, load_done},   32'd0);
      check({tag, "_err"},     {31'd0, err_timeout}, 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outs("rst0");
      rst_n = 1'b1;
      @(negedge clk);

      // Full load, 50-cycle spacing.
      send_word(32'h04030201, 1'b0, 16'd0, 1'b0, 50);
      send_word(32'hDDCCBBAA, 1'b0, 16'd1, 1'b0, 50);
      send_word(32'h44332211, 1'b1, 16'd0, 1'b0, 50);
      send_word(32'h88776655, 1'b1, 16'd1, 1'b1, 50);
      drain("load_drain");
      check("load_done_sticky", {31'd0, load_done}, 32'd1);

      // Bytes after DONE must be ignored.
      for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 3);
      repeat (5) @(negedge clk);
      check("post_done_wdata", wdata, 32'h88776655);
      check("post_done_ld",    {31'd0, load_done}, 32'd1);
      check("post_done_addr",  {16'd0, addr},      32'd1);

      do_reset();
      check_reset_outs("rst_done");

      // Back-to-back strobes.
      for (int i = 0; i < 8; i++) begin
         rx_dv   = 1'b1;
         rx_byte = 8'(i);
         if (i == 3) push(1'b0, 16'd0, 32'h03020100, 1'b0);
         if (i == 7) push(1'b0, 16'd1, 32'h07060504, 1'b0);
         @(negedge clk);
      end
      rx_dv = 1'b0;
      drain("b2b_drain");

      // Reset in the middle of a word.
      do_reset();
      send(8'hA1, 2);
      send(8'hA2, 2);
      send(8'hA3, 2);
      do_reset();
      check_reset_outs("rst_mid");
      send_word(32'h40302010, 1'b0, 16'd0, 1'b0, 2);
      drain("midrst_drain");

      // Stale partial word followed by a long idle gap.
      do_reset();
      send(8'hAB, 2);
      send(8'hCD, 0);
      repeat (94) @(negedge clk);
      check("tmo_early", {31'd0, err_timeout}, 32'd0);
      repeat (10) @(negedge clk);
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      check("tmo_fired", {31'd0, err_timeout}, 32'd1);
`else
      check("tmo_fired", {31'd0, err_timeout}, 32'd0);
`endif
      repeat (40) @(negedge clk);
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      send_word(32'h04030201, 1'b0, 16'd0, 1'b0, 2);
`else
      send(8'h01, 2);
      push(1'b0, 16'd0, 32'h0201CDAB, 1'b0);
      send(8'h02, 2);
      send(8'h03, 2);
      send(8'h04, 2);
`endif
      drain("tmo_drain");
      repeat (5) @(negedge clk);
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      check("tmo_err_sticky", {31'd0, err_timeout}, 32'd1);
      check("tmo_wdata", wdata, 32'h04030201);
`else
      check("tmo_err_sticky", {31'd0, err_timeout}, 32'd0);
      check("tmo_wdata", wdata, 32'h0201CDAB);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Byte-to-word assembler between `uart_rx` and the instruction/data memory write ports of the UART loader. It collects little-endian bytes from the receiver strobe into 32-bit words and issues one-cycle write commands with a running address. It fills the instruction region first, then the data region, then raises a sticky load-complete flag. An optional inter-byte timeout discards stale partial words.

## Interface
- `MEM_SIZE`, default 2: words per region; the instruction region and the data region each hold `MEM_SIZE` words.
- `TIMEOUT_CLKS`, default 208340 (10417*20): idle clocks tolerated inside a partial word; used only with the timeout feature.
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_dv` in 1: one-cycle byte-valid strobe from `uart_rx`.
- `rx_byte` in 8: received byte, valid when `rx_dv`=1.
- `wr_en` out 1: one-cycle memory write strobe.
- `mem_sel` out 1: target region, 0 = instruction, 1 = data; valid with `wr_en`.
- `addr` out 16: word address inside the selected region; valid with `wr_en`.
- `wdata` out 32: assembled word; valid with `wr_en`.
- `load_done` out 1: sticky; all 2*`MEM_SIZE` words written.
- `err_timeout` out 1: sticky; at least one partial word was discarded.

## Operation
- States:
  - IDLE: `byte_cnt`=0, waiting for a byte.
  - COLLECT: 1–3 bytes held.
  - WRITE: one cycle, `wr_en`=1.
  - DONE: terminal.
- Byte order is little-endian: byte 0 goes to `wdata[7:0]`, byte 3 to `wdata[31:24]`.
- Transitions:
  - IDLE + `rx_dv` → COLLECT, with `byte_cnt`=1.
  - In COLLECT, `rx_dv` with `byte_cnt`<3 stores the byte and increments `byte_cnt`.
  - In COLLECT, `rx_dv` with `byte_cnt`=3 → WRITE.
  - WRITE → IDLE, or → DONE if this write was the last word.
  - WRITE + `rx_dv` in the same cycle: the byte is accepted as byte 0 of the next word → COLLECT. This is ignored if the write was the last word.
- Address sequencing:
  - Word k, for k=0..2*`MEM_SIZE`-1, is written with `mem_sel`=(k ≥ `MEM_SIZE`) and `addr`=k mod `MEM_SIZE`.
  - Internal `word_idx` is `$clog2(2*MEM_SIZE)+1` bits wide, compared by equality. No wrap occurs, because DONE is terminal.
- DONE:
  - `load_done`=1.
  - All `rx_dv` are ignored.
  - `wr_en` stays 0.
  - Only `rst_n`=0 leaves DONE.
- `addr`, `mem_sel` and `wdata` hold their last written values outside WRITE.

## Timing
- Reset (`rst_n`=0 at a `clk` edge, from any state, including mid-word or during WRITE):
  - State returns to IDLE, with `byte_cnt`=0 and `word_idx`=0.
  - Outputs: `wr_en`=0, `mem_sel`=0, `addr`=0, `wdata`=0, `load_done`=0, `err_timeout`=0.
  - Any partial word is dropped.
- Latency: `wr_en` rises in the cycle after the edge that sampled the 4th `rx_dv`, and lasts exactly 1 cycle.
- `load_done` rises in the same cycle as the final `wr_en` and remains 1.
- `rx_dv` is assumed to be a single cycle. A `rx_dv` held for N cycles counts as N bytes; there is no edge detection.
- Minimum byte spacing is 1 cycle. Back-to-back strobes are fully supported.

## Configuration
- `UART_WORD_PACKER_TIMEOUT_EN` defined:
  - A counter runs in COLLECT and clears on every accepted `rx_dv`.
  - When it reaches `TIMEOUT_CLKS`: the partial word is discarded, `byte_cnt`=0, state → IDLE, and `err_timeout` is set to 1 (sticky).
  - `word_idx` is unchanged.
  - If `rx_dv` arrives in the same cycle the limit is reached, the byte wins and no timeout occurs.
- Not defined:
  - There is no counter, and partial words are held indefinitely.
  - `err_timeout` is tied to 0.
  - Port list is identical.

## Test plan
- Reset and load: `MEM_SIZE`=2; send bytes 01 02 03 04, AA BB CC DD, 11 22 33 44, 55 66 77 88 spaced 50 cycles apart. Required: four `wr_en` pulses with (`mem_sel`,`addr`,`wdata`) = (0,0,04030201), (0,1,DDCCBBAA), (1,0,44332211), (1,1,88776655); `load_done`=1 with the 4th pulse.
- Post-done ignore: after the previous scenario, send 4 more bytes. Required: no `wr_en`; `wdata` stays 88776655; `load_done` stays 1.
- Back-to-back: `rx_dv` high on 8 consecutive cycles with bytes 00..07. Required: `wr_en` one cycle after bytes 03 and 07; words 03020100 and 07060504 at instruction `addr` 0 and 1.
- Reset mid-word: send 3 bytes, pull `rst_n`=0 for 1 cycle, then send 10 20 30 40. Required: a single write of 40302010 at (`mem_sel`=0, `addr`=0).
- Timeout (macro on, `TIMEOUT_CLKS`=100): send 2 bytes, idle 150 cycles, then send 01 02 03 04. Required: `err_timeout`=1 about 100 cycles after the 2nd byte; next write is 04030201 at `addr` 0.
- Timeout off: repeat the timeout stimulus without the macro. Required: `err_timeout`=0; first write is 02010000 + combination = {02,01,B1,B0}, i.e. the two stale bytes plus 01 02.
